// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone bus arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StAbort
  } arb_state_e;

  // Width of a master index; a single master still needs one bit.
  function automatic int unsigned gnt_id_width(int unsigned num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester at or after the start pointer, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IdW = gnt_id_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IdW-1:0]         start_i,
  output logic [IdW-1:0]         idx_o,
  output logic                   found_o
);

  int unsigned pos;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      pos = (32'(start_i) + i) % NUM_MASTERS;
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IdW'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus arbiter with bus lock and a per-grant ack/err watchdog.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 256,
  localparam int unsigned IdW = gnt_id_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] cyc_i,
  input  logic                   ack_i,
  input  logic                   err_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IdW-1:0]         gnt_id_o,
  output logic                   gnt_valid_o,
  output logic                   abort_err_o,
  output logic                   timeout_o
);

  localparam int unsigned            CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0]        CntMax  = CntW'(TIMEOUT - 1);
  localparam logic [IdW-1:0]         LastRst = IdW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] OneHot0 = NUM_MASTERS'(1);

  arb_state_e      state_q;
  logic [IdW-1:0]  last_q;
  logic [CntW-1:0] cnt_q;
  logic [IdW-1:0]  start_ptr;
  logic [IdW-1:0]  pick_idx;
  logic            pick_found;

  always_comb begin
    start_ptr = (last_q == LastRst) ? '0 : last_q + IdW'(1);
  end

  wb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req_i  (cyc_i),
    .start_i(start_ptr),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= LastRst;
      cnt_q       <= '0;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
      abort_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      abort_err_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q     <= StGrant;
            gnt_o       <= OneHot0 << pick_idx;
            gnt_id_o    <= pick_idx;
            gnt_valid_o <= 1'b1;
            last_q      <= pick_idx;
            cnt_q       <= '0;
          end
        end
        StGrant: begin
          // Release beats ack, and ack beats the timeout threshold.
          if (!cyc_i[gnt_id_o]) begin
            state_q     <= StIdle;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            gnt_valid_o <= 1'b0;
            cnt_q       <= '0;
          end else if (ack_i || err_i) begin
            cnt_q <= '0;
          end else if (cnt_q == CntMax) begin
            state_q     <= StAbort;
            abort_err_o <= 1'b1;
            timeout_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAbort: begin
          // Slave responses are ignored; wait only for the master to let go.
          if (!cyc_i[gnt_id_o]) begin
            state_q     <= StIdle;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            gnt_valid_o <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: a 2-master and a 4-master instance, both with TIMEOUT=8.
module tb_wb_arbiter_rr;

  logic       clk;
  logic       rst;

  logic [1:0] c2;
  logic       a2, e2;
  logic [1:0] g2;
  logic [0:0] id2;
  logic       v2, ab2, to2;

  logic [3:0] c4;
  logic       a4, e4;
  logic [3:0] g4;
  logic [1:0] id4;
  logic       v4, ab4, to4;

  int n_assert = 0;
  int n_fail   = 0;

  wb_arbiter_rr #(
    .NUM_MASTERS(2),
    .TIMEOUT    (8)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .cyc_i      (c2),
    .ack_i      (a2),
    .err_i      (e2),
    .gnt_o      (g2),
    .gnt_id_o   (id2),
    .gnt_valid_o(v2),
    .abort_err_o(ab2),
    .timeout_o  (to2)
  );

  wb_arbiter_rr #(
    .NUM_MASTERS(4),
    .TIMEOUT    (8)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .cyc_i      (c4),
    .ack_i      (a4),
    .err_i      (e4),
    .gnt_o      (g4),
    .gnt_id_o   (id4),
    .gnt_valid_o(v4),
    .abort_err_o(ab4),
    .timeout_o  (to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    c2  = '0; a2 = 1'b0; e2 = 1'b0;
    c4  = '0; a4 = 1'b0; e4 = 1'b0;
    tick();
    tick();
    chk("rst_gnt2", 32'(g2), 32'h0);
    chk("rst_id2", 32'(id2), 32'h0);
    chk("rst_valid2", 32'(v2), 32'h0);
    chk("rst_abort2", 32'(ab2), 32'h0);
    chk("rst_timeout2", 32'(to2), 32'h0);
    chk("rst_gnt4", 32'(g4), 32'h0);

    // Both masters request from reset release: master 0 first, then master 1.
    rst = 1'b0;
    c2  = 2'b11;
    tick();
    chk("first_gnt", 32'(g2), 32'h1);
    chk("first_id", 32'(id2), 32'h0);
    chk("first_valid", 32'(v2), 32'h1);
    c2 = 2'b10;
    tick();
    chk("idle_gap_gnt", 32'(g2), 32'h0);
    chk("idle_gap_valid", 32'(v2), 32'h0);
    tick();
    chk("second_gnt", 32'(g2), 32'h2);
    chk("second_id", 32'(id2), 32'h1);

    // Master 1 keeps the bus for 10 cycles with 4 acks while master 0 also requests.
    for (int i = 0; i < 10; i++) begin
      c2 = 2'b11;
      a2 = (i % 2 == 1) && (i < 8);
      tick();
      chk("lock_gnt", 32'(g2), 32'h2);
      chk("lock_abort", 32'(ab2), 32'h0);
    end
    a2 = 1'b0;
    c2 = 2'b01;
    tick();
    chk("lock_release", 32'(g2), 32'h0);
    tick();
    chk("after_lock_gnt", 32'(g2), 32'h1);
    c2 = 2'b00;
    tick();
    chk("after_lock_idle", 32'(v2), 32'h0);

    // Timeout: no ack, abort pulse 8 cycles after the grant.
    c2 = 2'b01;
    tick();
    chk("to_gnt", 32'(g2), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait_abort", 32'(ab2), 32'h0);
      chk("to_wait_gnt", 32'(g2), 32'h1);
    end
    tick();
    chk("to_abort_pulse", 32'(ab2), 32'h1);
    chk("to_flag", 32'(to2), 32'h1);
    chk("to_abort_gnt", 32'(g2), 32'h1);
    a2 = 1'b1;
    tick();
    a2 = 1'b0;
    chk("to_abort_once", 32'(ab2), 32'h0);
    chk("to_abort_held", 32'(g2), 32'h1);
    c2 = 2'b00;
    tick();
    chk("to_release_gnt", 32'(g2), 32'h0);
    chk("to_sticky", 32'(to2), 32'h1);

    // Ack exactly at the threshold cycle: no abort and the wait restarts.
    c2 = 2'b01;
    tick();
    chk("ackth_gnt", 32'(g2), 32'h1);
    for (int i = 0; i < 7; i++) tick();
    a2 = 1'b1;
    tick();
    a2 = 1'b0;
    chk("ackth_no_abort", 32'(ab2), 32'h0);
    chk("ackth_gnt_held", 32'(g2), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("ackth_restart", 32'(ab2), 32'h0);
    end
    tick();
    chk("ackth_late_abort", 32'(ab2), 32'h1);
    c2 = 2'b00;
    tick();
    chk("ackth_release", 32'(v2), 32'h0);

    // Master drops cyc on the threshold cycle: plain release, no abort.
    c2 = 2'b01;
    tick();
    chk("dropth_gnt", 32'(g2), 32'h1);
    for (int i = 0; i < 7; i++) tick();
    c2 = 2'b00;
    tick();
    chk("dropth_gnt_clear", 32'(g2), 32'h0);
    chk("dropth_no_abort", 32'(ab2), 32'h0);

    // Reset in the middle of an abort with cyc still high.
    c2 = 2'b01;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("rstab_in_abort", 32'(ab2), 32'h1);
    rst = 1'b1;
    tick();
    chk("rstab_gnt", 32'(g2), 32'h0);
    chk("rstab_id", 32'(id2), 32'h0);
    chk("rstab_valid", 32'(v2), 32'h0);
    chk("rstab_abort", 32'(ab2), 32'h0);
    chk("rstab_timeout", 32'(to2), 32'h0);
    rst = 1'b0;
    tick();
    chk("rstab_regrant", 32'(g2), 32'h1);
    chk("rstab_regrant_id", 32'(id2), 32'h0);
    c2 = 2'b00;
    tick();

    // Four masters all requesting, each releasing after one ack: order 0,1,2,3,0.
    begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      c4 = 4'b1111;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("rr4_id", 32'(id4), 32'(exp_order[k]));
        chk("rr4_gnt", 32'(g4), 32'h1 << exp_order[k]);
        a4 = 1'b1;
        tick();
        a4 = 1'b0;
        c4[exp_order[k]] = 1'b0;
        tick();
        chk("rr4_gap", 32'(v4), 32'h0);
        c4 = 4'b1111;
      end
      c4 = 4'b0000;
      tick();
      chk("rr4_no_timeout", 32'(to4), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
